// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared colour types and constants for the pixel pipeline
package pixel_pkg;

  localparam int PIX_RGB_W = 12;
  localparam int MAX_LAYERS = 8;

  typedef logic [PIX_RGB_W-1:0] rgb_t;

  localparam rgb_t PIX_TRANSPARENT_KEY = 12'hF0F;
  localparam rgb_t BLACK = 12'h000;

endpackage

// File: rtl/layer_priority_mux.sv
// rtl/layer_priority_mux.sv - combinational lowest-index-wins layer select
module layer_priority_mux
  import pixel_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int RGB_W      = PIX_RGB_W
) (
  input  logic [NUM_LAYERS-1:0]       opaque,
  input  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb,
  output logic                        hit,
  output logic [RGB_W-1:0]            color
);

  // Walk from the lowest priority upward so the last assignment is the winner.
  always_comb begin
    hit   = 1'b0;
    color = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (opaque[i]) begin
        hit   = 1'b1;
        color = layer_rgb[i*RGB_W +: RGB_W];
      end
    end
  end

endmodule

// File: rtl/pixel_compositor.sv
// rtl/pixel_compositor.sv - three-stage layer compositor with frame-latched config and collision flags
module pixel_compositor
  import pixel_pkg::*;
#(
  parameter int                NUM_LAYERS      = 4,
  parameter int                RGB_W           = PIX_RGB_W,
  parameter bit                KEY_EN          = 1'b1,
  parameter logic [RGB_W-1:0]  TRANSPARENT_KEY = RGB_W'(PIX_TRANSPARENT_KEY)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        video_on,
  input  logic                        hsync_in,
  input  logic                        vsync_in,
  input  logic                        frame_start,
  input  logic [NUM_LAYERS-1:0]       layer_on,
  input  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb,
  input  logic [NUM_LAYERS-1:0]       layer_enable,
  input  logic [RGB_W-1:0]            bg_rgb,
  output logic [RGB_W-1:0]            rgb,
  output logic                        hsync_out,
  output logic                        vsync_out,
  output logic [NUM_LAYERS-1:0]       collision,
  output logic                        collision_valid
);

  localparam logic [RGB_W-1:0] OFF_COLOR = RGB_W'(BLACK);

  logic [NUM_LAYERS-1:0]       en_q;
  logic [RGB_W-1:0]            bg_q;
  logic [NUM_LAYERS-1:0]       opaque;
  logic                        s1_video;
  logic [NUM_LAYERS-1:0]       s1_opaque;
  logic [NUM_LAYERS*RGB_W-1:0] s1_rgb;
  logic                        sel_hit;
  logic [RGB_W-1:0]            sel_rgb;
  logic [RGB_W-1:0]            s2_rgb;
  logic [2:0]                  hsync_taps;
  logic [2:0]                  vsync_taps;
  logic                        multi_hit;
  logic [NUM_LAYERS-1:0]       contrib;
  logic [NUM_LAYERS-1:0]       acc;

  // Software config only changes at frame boundaries so a frame is never torn.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q <= '1;
      bg_q <= '0;
    end else if (frame_start) begin
      en_q <= layer_enable;
      bg_q <= bg_rgb;
    end
  end

  always_comb begin
    opaque = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      opaque[i] = layer_on[i] & en_q[i]
                & ~(KEY_EN && (layer_rgb[i*RGB_W +: RGB_W] == TRANSPARENT_KEY));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_video  <= 1'b0;
      s1_opaque <= '0;
      s1_rgb    <= '0;
    end else begin
      s1_video  <= video_on;
      s1_opaque <= opaque;
      s1_rgb    <= layer_rgb;
    end
  end

  layer_priority_mux #(
    .NUM_LAYERS (NUM_LAYERS),
    .RGB_W      (RGB_W)
  ) u_mux (
    .opaque    (s1_opaque),
    .layer_rgb (s1_rgb),
    .hit       (sel_hit),
    .color     (sel_rgb)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_rgb <= '0;
      rgb    <= '0;
    end else begin
      s2_rgb <= !s1_video ? OFF_COLOR : (sel_hit ? sel_rgb : bg_q);
      rgb    <= s2_rgb;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync_taps <= '1;
      vsync_taps <= '1;
    end else begin
      hsync_taps <= {hsync_taps[1:0], hsync_in};
      vsync_taps <= {vsync_taps[1:0], vsync_in};
    end
  end

  assign hsync_out = hsync_taps[2];
  assign vsync_out = vsync_taps[2];

  // Clearing the lowest set bit leaves something only when two or more layers overlap.
  assign multi_hit = |(s1_opaque & (s1_opaque - NUM_LAYERS'(1)));
  assign contrib   = (s1_video && multi_hit) ? s1_opaque : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc             <= '0;
      collision       <= '0;
      collision_valid <= 1'b0;
    end else begin
      collision_valid <= frame_start;
      if (frame_start) begin
        collision <= acc | contrib;
        acc       <= '0;
      end else begin
        acc <= acc | contrib;
      end
    end
  end

endmodule

// File: doc/pixel_compositor.md
# pixel_compositor

Parametrised, pipelined pixel compositor that merges up to NUM_LAYERS sprite/overlay layers into one RGB stream for the VGA DAC. Sits between the per-layer drawing blocks (input viewer, sprites, text) and the VGA output pins. Provides fixed-priority layer selection, colour-key transparency, a frame-latched configuration shadow, sync-signal delay matching, and per-frame layer collision detection for game logic.

## Interface
Parameters:
- NUM_LAYERS, 4, number of input layers (1..8); index 0 is highest priority.
- RGB_W, 12, colour width per pixel.
- KEY_EN, 1, enables colour-key transparency.
- TRANSPARENT_KEY, 12'hF0F, colour treated as transparent when KEY_EN=1.

Ports (clock and reset first):
- clk  in  1  system pixel-pipeline clock (100 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- video_on  in  1  active-video flag from VGA controller.
- hsync_in, vsync_in  in  1 each  syncs from VGA controller.
- frame_start  in  1  one-cycle pulse, asserted during vertical blanking.
- layer_on  in  NUM_LAYERS  per-layer pixel-hit flags.
- layer_rgb  in  NUM_LAYERS*RGB_W  packed colours; layer i at [i*RGB_W +: RGB_W].
- layer_enable  in  NUM_LAYERS  software layer mask (shadowed).
- bg_rgb  in  RGB_W  background colour (shadowed).
- rgb  out  RGB_W  composited pixel to DAC.
- hsync_out, vsync_out  out  1 each  syncs delayed to match rgb.
- collision  out  NUM_LAYERS  per-layer overlap flags for the previous frame.
- collision_valid  out  1  one-cycle pulse when collision updates.

## Operation
- Shadow registers: en_q and bg_q load layer_enable/bg_rgb on clk edge where frame_start=1; otherwise hold. Reset: en_q = all ones, bg_q = 0.
- Opaque: opaque[i] = layer_on[i] & en_q[i] & ~(KEY_EN & layer_rgb_i == TRANSPARENT_KEY).
- Selection: lowest-index opaque layer wins; none opaque -> bg_q; video inactive -> 0.
- Collision accumulator acc[i] set when, at stage 2 with video active, opaque[i]=1 and any other opaque bit is 1. Sticky until frame end.
- On frame_start edge: collision <= acc | same-cycle contribution; acc <= 0; collision_valid=1 next cycle only.
- frame_start while pixels in flight is not supported; the source guarantees it only in vblank.
- Simultaneous frame_start and layer_enable change: new value takes effect from the next cycle's stage-1 sample.

## Timing
- Three-stage pipeline: S1 registers video_on, opaque vector, layer colours; S2 priority select into intermediate colour and collision update; S3 registers rgb.
- Latency: inputs at edge N appear on rgb after edge N+3.
- hsync_out/vsync_out: 3-tap shift registers, same latency as rgb.
- Throughput: one pixel per clk, no stalls, no back-pressure.
- Reset (async assert, sync-free deassert use): rgb=0, all pipeline colour regs=0, video flags=0, sync taps=1 (idle high), collision=0, collision_valid=0, acc=0.
- Reset mid-frame: pipeline flushes to black; first valid pixel 3 cycles after first post-reset active input.

## Structure
- Shared package pixel_pkg: RGB_W, MAX_LAYERS=8, TRANSPARENT_KEY default, rgb_t typedef, color constants (BLACK=12'h000).
- One natural sub-module: layer_priority_mux (combinational lowest-index-wins select over NUM_LAYERS, outputs hit flag and colour); reused by future line-buffer compositors.
- Sync delay and collision logic stay in pixel_compositor.

## Test plan
- Reset: hold reset_n=0 with video_on=1 -> rgb=12'h000, hsync_out=vsync_out=1, collision=0.
- Priority: layers 1 and 3 on (12'h0F0, 12'h00F), enable=4'hF -> rgb=12'h0F0 exactly 3 cycles later; hsync_in pulse aligns with it.
- Transparency: layer 0 on with 12'hF0F, layer 2 on with 12'h123 -> rgb=12'h123; no layer on -> bg_q.
- Shadowing: change layer_enable to 4'hE mid-frame -> layer 0 still shown; after frame_start -> layer 0 suppressed.
- Collision: layers 0 and 2 opaque on same pixel once in frame, then frame_start -> collision=4'b0101, collision_valid high one cycle; next clean frame -> 4'b0000.
- Blanking: video_on=0 with layers on -> rgb=12'h000 after 3 cycles; no collision accumulated.
